// File: rtl/mips_cpu_mem_sequencer.sv
// mips_cpu_mem_sequencer
// Multi-cycle data-memory access sequencer between the CPU load/store stage
// and an Avalon-style data bus with waitrequest. One access in flight at a
// time; stall is raised to the pipeline while busy.
// Optional feature: define MIPS_MEM_SEQ_ALIGN_CHECK_EN to reject misaligned
// halfword/word requests with rsp_err instead of silently aligning them.
module mips_cpu_mem_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [3:0]  avm_byteenable,
    output logic [31:0] avm_writedata,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        rsp_valid,
    output logic        rsp_we,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_rd,
    output logic        rsp_err,
    output logic        stall
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

    localparam logic [2:0] OP_LB = 3'd0;
    localparam logic [2:0] OP_LH = 3'd2;
    localparam logic [2:0] OP_LW = 3'd4;

    // Access width of an opcode; loads and stores share the encoding order.
    function automatic size_t op_size(input logic [2:0] op);
        case (op)
            3'd2, 3'd3, 3'd6: op_size = SZ_HALF;
            3'd4, 3'd7:       op_size = SZ_WORD;
            default:          op_size = SZ_BYTE;
        endcase
    endfunction

    state_t      state, state_nx;
    logic [2:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [4:0]  rd_q;
    logic        err_q;
    logic [31:0] result_q;

    size_t       req_size;
    logic        req_bad;
    logic [31:0] req_addr_eff;

    size_t       size_q;
    logic        is_load;
    logic [1:0]  lane;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] shifted;
    logic [31:0] load_ext;

    assign size_q  = op_size(op_q);
    assign is_load = (op_q <= OP_LW);
    assign lane    = addr_q[1:0];

    // Classify the incoming request: misalignment error or forced alignment.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        req_size     = op_size(req_op);
        req_bad      = 1'b0;
        req_addr_eff = req_addr;
`ifdef MIPS_MEM_SEQ_ALIGN_CHECK_EN
        req_bad = ((req_size == SZ_HALF) && req_addr[0]) ||
                  ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
        if (req_size == SZ_HALF)
            req_addr_eff[0] = 1'b0;
        else if (req_size == SZ_WORD)
            req_addr_eff[1:0] = 2'b00;
`endif
    end

    // Lane steering: byte enables, replicated store data, extended load data.
    always_comb begin
        lane_be    = 4'hF;
        lane_wdata = wdata_q;
        shifted    = avm_readdata >> {lane, 3'b000};
        load_ext   = avm_readdata;
        case (size_q)
            SZ_BYTE: begin
                lane_be    = 4'b0001 << lane;
                lane_wdata = {4{wdata_q[7:0]}};
                load_ext   = (op_q == OP_LB) ? {{24{shifted[7]}}, shifted[7:0]}
                                             : {24'd0, shifted[7:0]};
            end
            SZ_HALF: begin
                lane_be    = 4'b0011 << lane;
                lane_wdata = {2{wdata_q[15:0]}};
                load_ext   = (op_q == OP_LH) ? {{16{shifted[15]}}, shifted[15:0]}
                                             : {16'd0, shifted[15:0]};
            end
            default: ;
        endcase
    end

    // Next-state and state-decoded outputs; nothing here depends on req_valid
    // except the next state.
    always_comb begin
        state_nx       = state;
        req_ready      = 1'b0;
        stall          = 1'b1;
        avm_read       = 1'b0;
        avm_write      = 1'b0;
        avm_address    = 32'd0;
        avm_byteenable = 4'd0;
        avm_writedata  = 32'd0;
        rsp_valid      = 1'b0;
        rsp_we         = 1'b0;
        rsp_data       = 32'd0;
        rsp_rd         = 5'd0;
        rsp_err        = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                stall     = 1'b0;
                if (req_valid)
                    state_nx = req_bad ? RESP : ACCESS;
            end
            ACCESS: begin
                avm_read       = is_load;
                avm_write      = !is_load;
                avm_address    = {addr_q[31:2], 2'b00};
                avm_byteenable = lane_be;
                avm_writedata  = is_load ? 32'd0 : lane_wdata;
                if (!avm_waitrequest)
                    state_nx = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_we    = is_load && !err_q;
                rsp_data  = result_q;
                rsp_rd    = rd_q;
                rsp_err   = err_q;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register plus request capture and load-result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state    <= IDLE;
            op_q     <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rd_q     <= 5'd0;
            err_q    <= 1'b0;
            result_q <= 32'd0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req_valid) begin
                op_q     <= req_op;
                addr_q   <= req_addr_eff;
                wdata_q  <= req_wdata;
                rd_q     <= req_rd;
                err_q    <= req_bad;
                result_q <= 32'd0;
            end else if (state == ACCESS && !avm_waitrequest && is_load) begin
                result_q <= load_ext;
            end
        end
    end

endmodule

// File: tb/tb_mips_cpu_mem_sequencer.sv
// Self-checking bench for mips_cpu_mem_sequencer: directed cases from the
// access scenarios plus randomized transactions against an arithmetic model.
// Inputs are driven and outputs sampled on the falling edge.
module tb_mips_cpu_mem_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        rsp_valid;
    logic        rsp_we;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        rsp_err;
    logic        stall;

    int n_tests = 0;
    int n_fail  = 0;

    mips_cpu_mem_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_rd          (req_rd),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_byteenable  (avm_byteenable),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .rsp_valid       (rsp_valid),
        .rsp_we          (rsp_we),
        .rsp_data        (rsp_data),
        .rsp_rd          (rsp_rd),
        .rsp_err         (rsp_err),
        .stall           (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One complete transaction; expectations derived from byte arithmetic.
    task automatic do_txn(input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd,
                          input int waits, input logic [31:0] rdata);
        int          nbytes;
        int          k;
        bit          bad;
        bit          load;
        logic [31:0] mask;
        logic [31:0] exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_rsp;

        load   = (op <= 3'd4);
        nbytes = (op == 3'd2 || op == 3'd3 || op == 3'd6) ? 2 :
                 (op == 3'd4 || op == 3'd7) ? 4 : 1;
        k      = int'(addr[1:0]);
        bad    = 1'b0;
`ifdef MIPS_MEM_SEQ_ALIGN_CHECK_EN
        bad = (k % nbytes) != 0;
`else
        k = k - (k % nbytes);
`endif
        mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
        exp_be = ((32'd1 << nbytes) - 32'd1) << k;
        exp_wd = (nbytes == 1) ? (wdata & 32'hFF) * 32'h0101_0101 :
                 (nbytes == 2) ? (wdata & 32'hFFFF) * 32'h0001_0001 : wdata;
        exp_rsp = (rdata >> (8 * k)) & mask;
        if ((op == 3'd0 || op == 3'd2) && exp_rsp[8 * nbytes - 1])
            exp_rsp = exp_rsp | ~mask;
        if (!load || bad)
            exp_rsp = 32'd0;

        check("idle_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        req_rd    = rd;
        @(negedge clk);
        // Outside IDLE the request port is ignored; scramble it.
        req_valid = 1'($urandom);
        req_op    = 3'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_rd    = 5'($urandom);

        if (!bad) begin
            for (int c = 0; c <= waits; c++) begin
                check("acc_read",  {31'd0, avm_read},  {31'd0, load});
                check("acc_write", {31'd0, avm_write}, {31'd0, !load});
                check("acc_addr",  avm_address, {addr[31:2], 2'b00});
                check("acc_be",    {28'd0, avm_byteenable}, exp_be);
                if (!load)
                    check("acc_wdata", avm_writedata, exp_wd);
                check("acc_rsp_valid", {31'd0, rsp_valid}, 32'd0);
                check("acc_stall", {31'd0, stall}, 32'd1);
                check("acc_ready", {31'd0, req_ready}, 32'd0);
                avm_waitrequest = (c < waits);
                avm_readdata    = (c < waits) ? $urandom : rdata;
                @(negedge clk);
            end
        end
        avm_waitrequest = 1'($urandom);
        avm_readdata    = $urandom;

        check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("rsp_we",    {31'd0, rsp_we},    {31'd0, load && !bad});
        check("rsp_err",   {31'd0, rsp_err},   {31'd0, bad});
        check("rsp_data",  rsp_data, exp_rsp);
        check("rsp_rd",    {27'd0, rsp_rd}, {27'd0, rd});
        check("rsp_nocmd", {30'd0, avm_read, avm_write}, 32'd0);
        check("rsp_stall", {31'd0, stall}, 32'd1);
        req_valid = 1'b0;
        @(negedge clk);
        check("back_idle", {31'd0, req_ready}, 32'd1);
        check("idle_rsp",  {31'd0, rsp_valid}, 32'd0);
        check("idle_data", rsp_data, 32'd0);
        check("idle_stall", {31'd0, stall}, 32'd0);
        avm_waitrequest = 1'b0;
    endtask

    initial begin
        rst_n           = 1'b0;
        req_valid       = 1'b0;
        req_op          = 3'd0;
        req_addr        = 32'd0;
        req_wdata       = 32'd0;
        req_rd          = 5'd0;
        avm_waitrequest = 1'b0;
        avm_readdata    = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_outs", {26'd0, avm_read, avm_write, rsp_valid, rsp_we, rsp_err, stall}, 32'd0);
        check("rst_addr", avm_address, 32'd0);
        check("rst_data", rsp_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        do_txn(3'd4, 32'h0000_0100, 32'd0, 5'd9, 0, 32'h89AB_CDEF);           // LW
        do_txn(3'd0, 32'h0000_0103, 32'd0, 5'd3, 0, 32'h8000_0000);           // LB
        do_txn(3'd1, 32'h0000_0103, 32'd0, 5'd4, 1, 32'h8000_0000);           // LBU
        do_txn(3'd6, 32'h0000_0202, 32'h1234_ABCD, 5'd0, 3, 32'd0);           // SH
        do_txn(3'd2, 32'h0000_0011, 32'd0, 5'd17, 0, 32'h1234_F00D);          // LH misaligned
        do_txn(3'd7, 32'h0000_0303, 32'hCAFE_BABE, 5'd1, 2, 32'd0);           // SW misaligned
        do_txn(3'd3, 32'h0000_0402, 32'd0, 5'd31, 0, 32'hBEEF_0000);          // LHU upper

        // Randomized transactions.
        for (int i = 0; i < 300; i++)
            do_txn(3'($urandom), $urandom, $urandom, 5'($urandom),
                   int'($urandom_range(0, 3)), $urandom);

        // Reset in the middle of a waited access.
        req_valid = 1'b1;
        req_op    = 3'd4;
        req_addr  = 32'h0000_0500;
        req_rd    = 5'd7;
        @(negedge clk);
        req_valid       = 1'b0;
        avm_waitrequest = 1'b1;
        check("pre_rst_read", {31'd0, avm_read}, 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_read",  {31'd0, avm_read}, 32'd0);
        check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        check("mid_rst_stall", {31'd0, stall}, 32'd0);
        check("mid_rst_addr",  avm_address, 32'd0);
        @(negedge clk);
        rst_n           = 1'b1;
        avm_waitrequest = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_rsp",   {31'd0, rsp_valid}, 32'd0);
            check("post_rst_ready", {31'd0, req_ready}, 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
